sprite_mover: RTL and testbench

Parametrised, keyboard-driven sprite motion controller for the VGA game layer. It updates one square sprite's centre once per frame_clk (vsync-rate) from a USB HID keycode and clamps the sprite so it never leaves a configurable play-field. It also exports a registered direction state, an edge-contact flag and a combinational pixel hit for the colour mapper. It replaces the fixed-bounds, fixed-step single-ball movers.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_mover_if.sv | 26 ++
 rtl/sprite_axis_clamp.sv | 33 +++
 rtl/sprite_mover.sv | 150 +++++++++++++++
 tb/tb_sprite_mover.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion controller:
// direction encoding, HID movement keycodes and screen geometry.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    localparam logic [7:0] HID_W = 8'h1A;
    localparam logic [7:0] HID_S = 8'h16;
    localparam logic [7:0] HID_A = 8'h04;
    localparam logic [7:0] HID_D = 8'h07;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/sprite_mover_if.sv
// Keyboard, raster and sprite-state signals between the game layer
// (master) and the sprite mover (slave).
interface sprite_mover_if;
    import sprite_pkg::*;

    logic [7:0] keycode;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] SpriteX;
    logic [9:0] SpriteY;
    logic [9:0] SpriteS;
    dir_t       dir;
    logic       at_edge;
    logic       sprite_on;

    modport master (
        output keycode, DrawX, DrawY,
        input  SpriteX, SpriteY, SpriteS, dir, at_edge, sprite_on
    );

    modport slave (
        input  keycode, DrawX, DrawY,
        output SpriteX, SpriteY, SpriteS, dir, at_edge, sprite_on
    );

endinterface

// File: rtl/sprite_axis_clamp.sv
// One axis of the sprite position update: adds a signed delta and
// saturates the result into [lo, hi], flagging when saturation occurred.
module sprite_axis_clamp (
    input  logic [9:0]         pos,
    input  logic signed [10:0] delta,
    input  logic [9:0]         lo,
    input  logic [9:0]         hi,
    output logic [9:0]         next_pos,
    output logic               clamped
);

    logic signed [10:0] sum_s;
    logic signed [10:0] lo_s;
    logic signed [10:0] hi_s;

    // Signed 11-bit sum so a step below zero cannot wrap to a large value.
    always_comb begin
        sum_s = signed'({1'b0, pos}) + delta;
        lo_s  = signed'({1'b0, lo});
        hi_s  = signed'({1'b0, hi});
        if (sum_s < lo_s) begin
            next_pos = lo;
            clamped  = 1'b1;
        end else if (sum_s > hi_s) begin
            next_pos = hi;
            clamped  = 1'b1;
        end else begin
            next_pos = sum_s[9:0];
            clamped  = 1'b0;
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// Keyboard-driven sprite motion controller, one step per frame_clk edge,
// clamped to the play-field. Define SPRITE_MOVER_ACCEL_EN for hold-to-accelerate.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int         X_MIN        = 0,
    parameter int         X_MAX        = 639,
    parameter int         Y_MIN        = 0,
    parameter int         Y_MAX        = 479,
    parameter int         X_START      = 320,
    parameter int         Y_START      = 240,
    parameter int         SIZE         = 4,
    parameter int         STEP         = 1,
    parameter logic [7:0] KEY_UP       = HID_W,
    parameter logic [7:0] KEY_DOWN     = HID_S,
    parameter logic [7:0] KEY_LEFT     = HID_A,
    parameter logic [7:0] KEY_RIGHT    = HID_D,
    parameter int         ACCEL_FRAMES = 8,
    parameter int         MAX_STEP     = 4
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    sprite_mover_if.slave        bus
);

    if ((X_START < X_MIN + SIZE) || (X_START > X_MAX - SIZE) ||
        (Y_START < Y_MIN + SIZE) || (Y_START > Y_MAX - SIZE) || (STEP < 1)) begin : g_bad_params
        $error("sprite_mover: start position outside clamp window or STEP < 1");
    end

    dir_t               dir_r, dir_nxt_s;
    logic [9:0]         x_r, y_r, x_nxt_s, y_nxt_s;
    logic               at_edge_r, x_clamped_s, y_clamped_s;
    logic signed [10:0] step_s, dx_s, dy_s;
    logic signed [10:0] draw_dx_s, draw_dy_s;

    // Keycode to direction; anything unmapped means stand still.
    always_comb begin
        case (bus.keycode)
            KEY_UP:    dir_nxt_s = UP;
            KEY_DOWN:  dir_nxt_s = DOWN;
            KEY_LEFT:  dir_nxt_s = LEFT;
            KEY_RIGHT: dir_nxt_s = RIGHT;
            default:   dir_nxt_s = IDLE;
        endcase
    end

`ifdef SPRITE_MOVER_ACCEL_EN
    localparam int HOLD_MAX = ACCEL_FRAMES * MAX_STEP;
    logic [15:0] hold_r, hold_nxt_s, raw_step_s;

    // Hold counter restarts whenever the direction changes or the key is released.
    always_comb begin
        if ((dir_nxt_s == IDLE) || (dir_nxt_s != dir_r)) begin
            hold_nxt_s = 16'd0;
        end else if (hold_r >= 16'(HOLD_MAX)) begin
            hold_nxt_s = 16'(HOLD_MAX);
        end else begin
            hold_nxt_s = hold_r + 16'd1;
        end
    end

    // Speed grows by one pixel per ACCEL_FRAMES held, capped at MAX_STEP.
    always_comb begin
        raw_step_s = 16'(STEP) + (hold_nxt_s / 16'(ACCEL_FRAMES));
        if (raw_step_s > 16'(MAX_STEP)) begin
            step_s = 11'(MAX_STEP);
        end else begin
            step_s = signed'(raw_step_s[10:0]);
        end
    end

    // Hold counter register.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            hold_r <= 16'd0;
        end else begin
            hold_r <= hold_nxt_s;
        end
    end
`else
    logic unused_accel_s;
    assign unused_accel_s = (ACCEL_FRAMES == 0) ^ (MAX_STEP == 0);
    assign step_s         = 11'(STEP);
`endif

    // Per-axis signed delta from the decoded direction.
    always_comb begin
        dx_s = 11'sd0;
        dy_s = 11'sd0;
        case (dir_nxt_s)
            UP:      dy_s = -step_s;
            DOWN:    dy_s = step_s;
            LEFT:    dx_s = -step_s;
            RIGHT:   dx_s = step_s;
            default: begin
                dx_s = 11'sd0;
                dy_s = 11'sd0;
            end
        endcase
    end

    sprite_axis_clamp u_clamp_x (
        .pos      (x_r),
        .delta    (dx_s),
        .lo       (10'(X_MIN + SIZE)),
        .hi       (10'(X_MAX - SIZE)),
        .next_pos (x_nxt_s),
        .clamped  (x_clamped_s)
    );

    sprite_axis_clamp u_clamp_y (
        .pos      (y_r),
        .delta    (dy_s),
        .lo       (10'(Y_MIN + SIZE)),
        .hi       (10'(Y_MAX - SIZE)),
        .next_pos (y_nxt_s),
        .clamped  (y_clamped_s)
    );

    // Direction, position and wall-contact registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            dir_r     <= IDLE;
            x_r       <= 10'(X_START);
            y_r       <= 10'(Y_START);
            at_edge_r <= 1'b0;
        end else begin
            dir_r     <= dir_nxt_s;
            x_r       <= x_nxt_s;
            y_r       <= y_nxt_s;
            at_edge_r <= x_clamped_s | y_clamped_s;
        end
    end

    // Signed raster distance so pixels left of / above the sprite don't wrap.
    always_comb begin
        draw_dx_s = signed'({1'b0, bus.DrawX}) - signed'({1'b0, x_r});
        draw_dy_s = signed'({1'b0, bus.DrawY}) - signed'({1'b0, y_r});
    end

    assign bus.sprite_on = (draw_dx_s >= -11'(SIZE)) && (draw_dx_s <= 11'(SIZE)) &&
                           (draw_dy_s >= -11'(SIZE)) && (draw_dy_s <= 11'(SIZE));
    assign bus.SpriteX   = x_r;
    assign bus.SpriteY   = y_r;
    assign bus.SpriteS   = 10'(SIZE);
    assign bus.dir       = dir_r;
    assign bus.at_edge   = at_edge_r;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed, table-driven bench for sprite_mover with hand-computed expectations.
module tb_sprite_mover;
    import sprite_pkg::*;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   n_vec     = 0;
    int   n_bad     = 0;

    sprite_mover_if bus_if ();

    sprite_mover dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus_if)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [7:0] key;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [2:0] edir;
        logic       eedge;
    } vec_t;

    typedef struct {
        logic [9:0] dx;
        logic [9:0] dy;
        logic       eon;
    } pix_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frame(input logic [7:0] key);
        bus_if.keycode = key;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int ex, input int ey,
                               input int edir, input int eedge);
        check({tag, ".X"},    32'(bus_if.SpriteX), 32'(ex));
        check({tag, ".Y"},    32'(bus_if.SpriteY), 32'(ey));
        check({tag, ".dir"},  32'(bus_if.dir),     32'(edir));
        check({tag, ".edge"}, 32'(bus_if.at_edge), 32'(eedge));
    endtask

    vec_t tbl[15];
    pix_t pix[6];

    initial begin
        bus_if.keycode = 8'h00;
        bus_if.DrawX   = 10'd0;
        bus_if.DrawY   = 10'd0;

        // Reset held across an edge, then released between edges
        @(posedge frame_clk);
        #2;
        check_state("rst_hold", 320, 240, 0, 0);
        Reset = 1'b0;
        #1;
        check_state("rst_rel", 320, 240, 0, 0);
        check("size", 32'(bus_if.SpriteS), 32'd4);
        frame(8'h00);
        check_state("idle0", 320, 240, 0, 0);

`ifndef SPRITE_MOVER_ACCEL_EN
        for (int i = 0; i < 10; i++) begin
            tbl[i] = '{8'h07, 10'(321 + i), 10'd240, 3'd4, 1'b0};
        end
        tbl[10] = '{8'h04, 10'd329, 10'd240, 3'd3, 1'b0};
        tbl[11] = '{8'h00, 10'd329, 10'd240, 3'd0, 1'b0};
        tbl[12] = '{8'h55, 10'd329, 10'd240, 3'd0, 1'b0};
        tbl[13] = '{8'h16, 10'd329, 10'd241, 3'd2, 1'b0};
        tbl[14] = '{8'h00, 10'd329, 10'd241, 3'd0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            frame(tbl[i].key);
            check_state($sformatf("vec%0d", i), int'(tbl[i].ex), int'(tbl[i].ey),
                        int'(tbl[i].edir), int'(tbl[i].eedge));
        end

        // Sprite now at (329,241): edges of the square and a far-left pixel
        pix[0] = '{10'd333, 10'd241, 1'b1};
        pix[1] = '{10'd334, 10'd241, 1'b0};
        pix[2] = '{10'd325, 10'd237, 1'b1};
        pix[3] = '{10'd324, 10'd241, 1'b0};
        pix[4] = '{10'd329, 10'd246, 1'b0};
        pix[5] = '{10'd0,   10'd0,   1'b0};
        for (int i = 0; i < 6; i++) begin
            bus_if.DrawX = pix[i].dx;
            bus_if.DrawY = pix[i].dy;
            #1;
            check($sformatf("pix%0d", i), 32'(bus_if.sprite_on), 32'(pix[i].eon));
        end

        // Right wall: walk to 634, then push into the wall
        for (int i = 0; i < 305; i++) frame(8'h07);
        check_state("rw_634", 634, 241, 4, 0);
        frame(8'h07);
        check_state("rw_635", 635, 241, 4, 0);
        for (int i = 0; i < 3; i++) begin
            frame(8'h07);
            check_state($sformatf("rw_push%0d", i), 635, 241, 4, 1);
        end
        frame(8'h00);
        check_state("rw_rel", 635, 241, 0, 0);

        // Top wall: walk to Y=5, then push; must saturate at 4, never wrap
        for (int i = 0; i < 236; i++) frame(8'h1A);
        check_state("tw_5", 635, 5, 1, 0);
        frame(8'h1A);
        check_state("tw_4", 635, 4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            frame(8'h1A);
            check_state($sformatf("tw_push%0d", i), 635, 4, 1, 1);
        end
        frame(8'h00);
        check_state("tw_rel", 635, 4, 0, 0);

        // Reset mid-motion acts immediately, without waiting for an edge
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        for (int i = 0; i < 7; i++) frame(8'h07);
        check_state("mm_327", 327, 240, 4, 0);
        #3;
        Reset = 1'b1;
        #1;
        check_state("mm_async", 320, 240, 0, 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        frame(8'h07);
        check_state("mm_resume", 321, 240, 4, 0);
`else
        // Accelerating hold: steps 1x8, 2x8, 3x8, then 4 thereafter
        for (int i = 1; i <= 40; i++) begin
            frame(8'h07);
            if (i == 8)  check_state("acc8",  328, 240, 4, 0);
            if (i == 16) check_state("acc16", 344, 240, 4, 0);
            if (i == 24) check_state("acc24", 368, 240, 4, 0);
        end
        check_state("acc40", 432, 240, 4, 0);
        frame(8'h04);
        check_state("acc_chg", 431, 240, 3, 0);
        frame(8'h04);
        check_state("acc_chg2", 430, 240, 3, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
